// File: rtl/wm_cycle_runner_pkg.sv
// Shared types and constants for the washing-machine cycle runner.
package wm_cycle_runner_pkg;

  localparam int DUR_W            = 5;
  localparam int TOT_W            = 8;
  localparam int DEFAULT_MAX_LOAD = 20;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WASH  = 3'd1,
    PH_RINSE = 3'd2,
    PH_SPIN  = 3'd3,
    PH_DONE  = 3'd4
  } phase_t;

  // Program order; anything outside the running phases falls back to IDLE.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_WASH:  return PH_RINSE;
      PH_RINSE: return PH_SPIN;
      PH_SPIN:  return PH_DONE;
      default:  return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/wm_cycle_runner_tick_prescaler.sv
// Minute-tick prescaler: counts 0..TICK_DIV-1 while enabled, tick marks the wrap cycle.
module wm_tick_prescaler #(
  parameter int TICK_DIV = 50,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Tick is independent of clear so the owner may clear on the tick itself.
  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wm_cycle_runner.sv
// Washing-machine program executor (WASH -> RINSE -> SPIN -> DONE) on a prescaled tick.
// Optional door interlock ports are enabled by defining WM_DOOR_LOCK_EN.
module wm_cycle_runner
  import wm_cycle_runner_pkg::*;
#(
  parameter int TICK_DIV = 50,
  parameter int MAX_LOAD = DEFAULT_MAX_LOAD,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef WM_DOOR_LOCK_EN
  input  logic             door_closed,
  output logic             door_lock,
`endif
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [DUR_W-1:0] wash_in,
  input  logic [DUR_W-1:0] rinse_in,
  input  logic [DUR_W-1:0] spin_in,
  input  logic [DUR_W-1:0] cloth_in,
  input  logic [TOT_W-1:0] total_in,
  output logic [2:0]       phase,
  output logic [DUR_W-1:0] phase_left,
  output logic [TOT_W-1:0] total_left,
  output logic             drum_en,
  output logic             spin_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cfg_mismatch
);

  phase_t           state_q, state_d;
  logic [DUR_W-1:0] phase_left_q, phase_left_d;
  logic [DUR_W-1:0] rinse_q, rinse_d, spin_q, spin_d;
  logic [TOT_W-1:0] total_left_q, total_left_d;
  logic [TOT_W-1:0] sum;
  logic             done_q, done_d, err_q, err_d, mis_q, mis_d;
  logic             start_q, start_edge, start_ok;
  logic             busy_w, hold, run, tick, pre_clr, advance;

  assign busy_w     = (state_q == PH_WASH) || (state_q == PH_RINSE) || (state_q == PH_SPIN);
  assign start_edge = start && !start_q;
  assign sum        = TOT_W'(wash_in) + TOT_W'(rinse_in) + TOT_W'(spin_in);

`ifdef WM_DOOR_LOCK_EN
  // An open door behaves exactly like pause and blocks new programs.
  assign hold      = pause || !door_closed;
  assign start_ok  = (int'(cloth_in) <= MAX_LOAD) && door_closed;
  assign door_lock = busy_w;
`else
  assign hold      = pause;
  assign start_ok  = (int'(cloth_in) <= MAX_LOAD);
`endif

  assign run = busy_w && !hold;

  wm_tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (run),
    .clear  (pre_clr),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PH_IDLE;
      phase_left_q <= '0;
      total_left_q <= '0;
      rinse_q      <= '0;
      spin_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mis_q        <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_left_q <= phase_left_d;
      total_left_q <= total_left_d;
      rinse_q      <= rinse_d;
      spin_q       <= spin_d;
      done_q       <= done_d;
      err_q        <= err_d;
      mis_q        <= mis_d;
      start_q      <= start;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_left_d = phase_left_q;
    total_left_d = total_left_q;
    rinse_d      = rinse_q;
    spin_d       = spin_q;
    done_d       = 1'b0;
    err_d        = err_q;
    mis_d        = mis_q;
    pre_clr      = 1'b0;
    advance      = 1'b0;

    if (abort) begin
      state_d      = PH_IDLE;
      phase_left_d = '0;
      total_left_d = '0;
      pre_clr      = 1'b1;
    end else if (!busy_w) begin
      if (start_edge) begin
        if (start_ok) begin
          state_d      = PH_WASH;
          phase_left_d = wash_in;
          total_left_d = sum;
          rinse_d      = rinse_in;
          spin_d       = spin_in;
          err_d        = 1'b0;
          mis_d        = (total_in != sum);
          pre_clr      = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (run) begin
      // A zero-length phase is entered with phase_left already 0 and leaves after one cycle.
      if (phase_left_q == '0) begin
        advance = 1'b1;
      end else if (tick) begin
        total_left_d = (total_left_q != '0) ? total_left_q - 1'b1 : '0;
        if (phase_left_q == DUR_W'(1)) advance = 1'b1;
        else phase_left_d = phase_left_q - 1'b1;
      end
    end

    if (advance) begin
      state_d = next_phase(state_q);
      pre_clr = 1'b1;
      case (state_d)
        PH_RINSE: phase_left_d = rinse_q;
        PH_SPIN:  phase_left_d = spin_q;
        default: begin
          phase_left_d = '0;
          total_left_d = '0;
          done_d       = 1'b1;
        end
      endcase
    end
  end

  assign phase        = state_q;
  assign phase_left   = phase_left_q;
  assign total_left   = total_left_q;
  assign busy         = busy_w;
  assign drum_en      = ((state_q == PH_WASH) || (state_q == PH_RINSE)) && !hold;
  assign spin_en      = (state_q == PH_SPIN) && !hold;
  assign done         = done_q;
  assign err          = err_q;
  assign cfg_mismatch = mis_q;

endmodule
